planificador_paralelo_serial: RTL and testbench
===============================================

Name: planificador_paralelo_serial

Overview:
- Byte-level scheduler in front of the paralelo_serial converter in the PCIe physical-layer TX path.
- Runs a post-reset training phase of COM symbols, then round-robin arbitrates N_REQ byte-stream requesters, e.g. lane FIFOs, with bounded bursts.
- Drives the converter's data_in/valid_in with one byte per clk_4f cycle.
- Emits COM (idle, valid_out=0) whenever no requester is served.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- BURST_MAX, 4, max consecutive bytes granted to one requester before forced rotation (>=1).
- TRAIN_CYCLES, 8, clk_4f cycles of COM emitted after reset before accepting data (>=1).
- COM_SYMBOL, 8'hBC, idle/training symbol.

Ports:
- clk_4f  in  1  byte clock; one clock domain, all logic on posedge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- valid_req  in  N_REQ  requester i has a byte available (first-word-fall-through).
- data_req  in  8*N_REQ  flattened bytes; requester i at [8i+7:8i].
- ready_req  out  N_REQ  pop strobe; at most one bit high; combinational from state and valid_req.
- data_out  out  8  registered byte to paralelo_serial data_in.
- valid_out  out  1  registered; to paralelo_serial valid_in.
- active  out  1  registered; high in ACTIVE state.
- grant_id  out  $clog2(N_REQ)  registered index of the last requester served.

Behaviour:
- Reset (reset=0): state=TRAIN, train_cnt=0, burst_cnt=0, owner=N_REQ-1 (so requester 0 wins first), data_out=COM_SYMBOL, valid_out=0, active=0, grant_id=0, ready_req=0.
- TRAIN: ready_req=0, valid_out=0, data_out=COM_SYMBOL; train_cnt increments each cycle. When train_cnt==TRAIN_CYCLES-1 -> ACTIVE, active=1 from the next cycle. First accept is possible in ACTIVE cycle 0.
- ACTIVE, per cycle:
  - locked = (burst_cnt!=0) && (burst_cnt<BURST_MAX) && valid_req[owner].
  - If locked, sel=owner. Otherwise sel=first i with valid_req[i] scanning owner+1, owner+2, ... mod N_REQ, with owner checked last.
  - If sel exists: ready_req[sel]=1; next cycle data_out=data_req[sel], valid_out=1, grant_id=sel, owner=sel; burst_cnt = locked ? burst_cnt+1 : 1.
  - If no valid_req: ready_req=0; next cycle valid_out=0, data_out=COM_SYMBOL, burst_cnt=0, owner unchanged.
- Latency: byte accepted in cycle k (ready_req high) appears on data_out/valid_out in cycle k+1. Throughput is 1 byte/cycle with no bubbles while any requester is valid.
- Boundary conditions:
  - Owner drops valid mid-burst: lock breaks and re-arbitration happens the same cycle; no idle bubble if another requester is valid.
  - burst_cnt==BURST_MAX: forced rotation. A sole valid requester is re-granted with no gap (burst_cnt restarts at 1).
  - burst_cnt saturates logic-wise at BURST_MAX; it never exceeds it.
  - reset asserted mid-operation: the byte popped in the same cycle is dropped. The requester has already popped it; this is the accepted loss. Restart at TRAIN.
  - No valid_req during ACTIVE: steady COM, active stays 1.

Optional Feature:
- ARB_FIXED_PRIO_EN
  - Defined: at each arbitration point (not locked), sel = lowest-index valid requester. Bursts and BURST_MAX locking are unchanged.
  - Undefined: round-robin as described above.
  - Ports are identical either way.

Decomposition:
- Package planificador_pkg:
  - COM_SYMBOL default.
  - State encoding localparams ST_TRAIN=1'b0, ST_ACTIVE=1'b1.
  - Index-width helper function.
- Sub-module rr_selector: combinational; inputs valid_req and start index, outputs sel and found; holds the ARB_FIXED_PRIO_EN variant.
- Top holds the FSM, counters and output registers.

Test Plan:
- Release reset with all valid_req=1 -> valid_out=0, data_out=8'hBC and ready_req=0 for 8 cycles; active=1 and first ready_req=4'b0001 in cycle 8; data_out=data_req[0] with valid_out=1 in cycle 9.
- Only requester 1 valid, bytes 0x11..0x1A -> ready_req=4'b0010 every cycle; data_out 0x11..0x1A consecutive with no COM gap across the burst boundary; grant_id=1.
- Requesters 0 and 2 continuously valid -> data_out pattern is 4 bytes from 0, 4 from 2, repeating; grant_id 0,0,0,0,2,2,2,2.
- Requester 0 valid for 2 bytes then drops while 3 is valid -> third accepted byte comes from 3 in the same cycle 0 drops; no idle cycle.
- reset pulsed low for 1 cycle mid-burst -> outputs return to BC/valid_out=0/active=0 asynchronously; 8 training cycles repeat before the next accept.
- With ARB_FIXED_PRIO_EN and requesters 1,3 valid -> 4 bytes from 1, then 1 again (lowest index), 3 never served while 1 stays valid.

Source files
------------

// File: rtl/planificador_pkg.sv
// Shared definitions for the planificador_paralelo_serial byte scheduler:
// default idle symbol, FSM state encoding and an index-width helper.
// Optional build macro used by this block: ARB_FIXED_PRIO_EN (see rr_selector).
package planificador_pkg;

    // K28.5-style comma used for training and idle fill.
    localparam logic [7:0] COM_SYMBOL_DEFAULT = 8'hBC;

    // Scheduler phases: post-reset training, then data arbitration.
    typedef enum logic {
        ST_TRAIN  = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Bits needed to index n items; never less than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/planificador_paralelo_serial_rr_selector.sv
// Combinational requester selector for planificador_paralelo_serial.
// Default: round-robin scan starting just after 'start', 'start' checked last.
// With ARB_FIXED_PRIO_EN defined: lowest-index valid requester wins.
module rr_selector
    import planificador_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] valid_req,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] sel,
    output logic             found
);

    // Scan from the far end toward the preferred end so the preferred hit lands last.
    always_comb begin
        sel   = '0;
        found = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (valid_req[i]) begin
                sel   = IDX_W'(i);
                found = 1'b1;
            end
        end
`else
        for (int k = N_REQ; k >= 1; k--) begin
            if (valid_req[(int'(start) + k) % N_REQ]) begin
                sel   = IDX_W'((int'(start) + k) % N_REQ);
                found = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/planificador_paralelo_serial.sv
// Byte scheduler feeding the paralelo_serial converter: COM training after
// reset, then bounded-burst arbitration among N_REQ FWFT byte sources.
// Idle cycles emit COM with valid_out low.
// Optional build macro: ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
module planificador_paralelo_serial
    import planificador_pkg::*;
#(
    parameter int         N_REQ        = 4,
    parameter int         BURST_MAX    = 4,
    parameter int         TRAIN_CYCLES = 8,
    parameter logic [7:0] COM_SYMBOL   = COM_SYMBOL_DEFAULT
) (
    input  logic                          clk_4f,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              valid_req,
    input  logic [8*N_REQ-1:0]            data_req,
    output logic [N_REQ-1:0]              ready_req,
    output logic [7:0]                    data_out,
    output logic                          valid_out,
    output logic                          active,
    output logic [idx_width(N_REQ)-1:0]   grant_id
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam int BW    = idx_width(BURST_MAX + 1);
    localparam int TW    = idx_width(TRAIN_CYCLES);

    state_t           state_reg,     state_next;
    logic [TW-1:0]    train_cnt_reg, train_cnt_next;
    logic [BW-1:0]    burst_cnt_reg, burst_cnt_next;
    logic [IDX_W-1:0] owner_reg,     owner_next;
    logic [7:0]       data_out_reg,  data_out_next;
    logic             valid_out_reg, valid_out_next;
    logic             active_reg,    active_next;
    logic [IDX_W-1:0] grant_id_reg,  grant_id_next;

    logic [7:0]       req_byte [N_REQ];
    logic [IDX_W-1:0] rr_sel;
    logic             rr_found;
    logic             locked;
    logic [IDX_W-1:0] sel;
    logic             take;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign req_byte[gi]  = data_req[8*gi +: 8];
            assign ready_req[gi] = take && (sel == IDX_W'(gi));
        end
    endgenerate

    rr_selector #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_selector (
        .valid_req (valid_req),
        .start     (owner_reg),
        .sel       (rr_sel),
        .found     (rr_found)
    );

    // Burst lock: keep the current owner while its burst is open and it still has data.
    always_comb begin
        locked = (state_reg == ST_ACTIVE) &&
                 (burst_cnt_reg != '0) &&
                 (burst_cnt_reg < BW'(BURST_MAX)) &&
                 valid_req[owner_reg];
        sel    = locked ? owner_reg : rr_sel;
        take   = (state_reg == ST_ACTIVE) && (locked || rr_found);
    end

    // Next-state and next-output logic for both phases.
    always_comb begin
        state_next     = state_reg;
        train_cnt_next = train_cnt_reg;
        burst_cnt_next = burst_cnt_reg;
        owner_next     = owner_reg;
        data_out_next  = COM_SYMBOL;
        valid_out_next = 1'b0;
        active_next    = active_reg;
        grant_id_next  = grant_id_reg;
        case (state_reg)
            ST_TRAIN: begin
                train_cnt_next = train_cnt_reg + 1'b1;
                active_next    = 1'b0;
                if (train_cnt_reg == TW'(TRAIN_CYCLES - 1)) begin
                    state_next     = ST_ACTIVE;
                    train_cnt_next = '0;
                    active_next    = 1'b1;
                end
            end
            ST_ACTIVE: begin
                active_next = 1'b1;
                if (take) begin
                    data_out_next  = req_byte[sel];
                    valid_out_next = 1'b1;
                    grant_id_next  = sel;
                    owner_next     = sel;
                    burst_cnt_next = locked ? burst_cnt_reg + 1'b1 : BW'(1);
                end else begin
                    burst_cnt_next = '0;
                end
            end
            default: begin
                state_next = ST_TRAIN;
            end
        endcase
    end

    // State and output registers; reset returns to training immediately.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_TRAIN;
            train_cnt_reg <= '0;
            burst_cnt_reg <= '0;
            owner_reg     <= IDX_W'(N_REQ - 1);
            data_out_reg  <= COM_SYMBOL;
            valid_out_reg <= 1'b0;
            active_reg    <= 1'b0;
            grant_id_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            train_cnt_reg <= train_cnt_next;
            burst_cnt_reg <= burst_cnt_next;
            owner_reg     <= owner_next;
            data_out_reg  <= data_out_next;
            valid_out_reg <= valid_out_next;
            active_reg    <= active_next;
            grant_id_reg  <= grant_id_next;
        end
    end

    assign data_out  = data_out_reg;
    assign valid_out = valid_out_reg;
    assign active    = active_reg;
    assign grant_id  = grant_id_reg;

endmodule

// File: tb/tb_planificador_paralelo_serial.sv
// Scoreboard bench for planificador_paralelo_serial: stimulus computes the
// expected pop and next-cycle output from a behavioural model and queues it;
// a negedge monitor pops and compares the registered outputs.
module tb_planificador_paralelo_serial;

    localparam int N  = 4;
    localparam int BM = 4;
    localparam int TC = 8;

    logic           clk_4f = 1'b0;
    logic           reset;
    logic [N-1:0]   valid_req;
    logic [8*N-1:0] data_req;
    logic [N-1:0]   ready_req;
    logic [7:0]     data_out;
    logic           valid_out;
    logic           active;
    logic [1:0]     grant_id;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic [1:0] g;
        logic       a;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    bit   mon_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    // behavioural model state
    int         m_train, m_cnt, m_owner, m_burst, m_grant;
    int         pops [N];
    logic [7:0] seq  [N];
    int         mode;

    always #5 clk_4f = ~clk_4f;

    planificador_paralelo_serial #(
        .N_REQ        (N),
        .BURST_MAX    (BM),
        .TRAIN_CYCLES (TC),
        .COM_SYMBOL   (8'hBC)
    ) dut (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .valid_req (valid_req),
        .data_req  (data_req),
        .ready_req (ready_req),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active),
        .grant_id  (grant_id)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // monitor: one expected output record per cycle
    always @(negedge clk_4f) begin
        if (mon_en) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty actual=0 required=1 t=%0t", $time);
            end else begin
                mon_e = q.pop_front();
                chk("valid_out", 32'(valid_out), 32'(mon_e.v));
                chk("data_out",  32'(data_out),  32'(mon_e.d));
                chk("grant_id",  32'(grant_id),  32'(mon_e.g));
                chk("active",    32'(active),    32'(mon_e.a));
                if (mon_e.v)
                    $display("txn t=%0t grant=%0d data=%02h", $time, mon_e.g, mon_e.d);
            end
        end
    end

    task automatic drive();
        logic [N-1:0] v;
        case (mode)
            0: begin
                v = 4'($urandom);
                if ($urandom_range(0, 3) == 0) v = '0;
            end
            1: v = 4'b1111;
            2: v = 4'b0010;
            3: v = 4'b0101;
            4: v = {1'b1, 2'b00, (pops[0] < 2)};
            default: v = 4'b1010;
        endcase
        valid_req = v;
        for (int i = 0; i < N; i++) data_req[8*i +: 8] = seq[i];
    endtask

    task automatic model_reset();
        m_train = 1; m_cnt = 0; m_owner = N - 1; m_burst = 0; m_grant = 0;
        for (int i = 0; i < N; i++) pops[i] = 0;
    endtask

    // one clock cycle: drive, predict, check pop, queue next-cycle output
    task automatic step();
        int           sel;
        bit           found, locked;
        logic [N-1:0] er;
        exp_t         nx;
        drive();
        er = '0;
        if (m_train != 0) begin
            nx.v = 1'b0; nx.d = 8'hBC; nx.g = 2'(m_grant); nx.a = (m_cnt == TC - 1);
            m_cnt++;
            if (m_cnt == TC) m_train = 0;
        end else begin
            locked = (m_burst > 0) && (m_burst < BM) && valid_req[m_owner];
            found  = 1'b0;
            sel    = 0;
            if (locked) begin
                sel = m_owner; found = 1'b1;
            end else begin
`ifdef ARB_FIXED_PRIO_EN
                for (int i = 0; i < N; i++)
                    if (!found && valid_req[i]) begin sel = i; found = 1'b1; end
`else
                for (int k = 1; k <= N; k++)
                    if (!found && valid_req[(m_owner + k) % N]) begin
                        sel = (m_owner + k) % N; found = 1'b1;
                    end
`endif
            end
            nx.a = 1'b1;
            if (found) begin
                er[sel] = 1'b1;
                nx.v = 1'b1; nx.d = data_req[8*sel +: 8]; nx.g = 2'(sel);
                m_burst = locked ? m_burst + 1 : 1;
                m_owner = sel; m_grant = sel;
                pops[sel]++;
                seq[sel] = (mode == 0) ? 8'($urandom) : seq[sel] + 8'd1;
            end else begin
                nx.v = 1'b0; nx.d = 8'hBC; nx.g = 2'(m_grant);
                m_burst = 0;
            end
        end
        @(negedge clk_4f);
        chk("ready_req", 32'(ready_req), 32'(er));
        q.push_back(nx);
        @(posedge clk_4f);
        #1;
    endtask

    // asynchronous reset pulse spanning one rising edge, with immediate output check
    task automatic do_reset();
        exp_t r;
        mon_en = 1'b0;
        q.delete();
        reset = 1'b0;
        #1;
        chk("rst_data_out",  32'(data_out),  32'h0BC);
        chk("rst_valid_out", 32'(valid_out), 32'h0);
        chk("rst_active",    32'(active),    32'h0);
        chk("rst_grant_id",  32'(grant_id),  32'h0);
        chk("rst_ready_req", 32'(ready_req), 32'h0);
        @(posedge clk_4f);
        #1;
        reset = 1'b1;
        model_reset();
        r.v = 1'b0; r.d = 8'hBC; r.g = 2'd0; r.a = 1'b0;
        q.push_back(r);
        mon_en = 1'b1;
    endtask

    task automatic run(input int m, input int n);
        mode = m;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset     = 1'b0;
        valid_req = '0;
        data_req  = '0;
        mode      = 1;
        for (int i = 0; i < N; i++) seq[i] = 8'(i * 16 + 1);
        valid_req = '1;
        @(posedge clk_4f);
        #1;
        do_reset();
        run(1, 14);                 // training with all valid, then first grants
        seq[1] = 8'h11;
        run(2, 12);                 // sole requester across burst boundaries
        run(3, 16);                 // two requesters alternate in bursts of 4
        do_reset();
        run(4, 14);                 // owner drops mid-burst, 3 takes over
        run(1, 11);
        valid_req = '1;
        do_reset();                 // reset in the middle of a burst
        run(0, 300);                // randomized traffic with idle gaps
        run(5, 12);                 // requesters 1 and 3
        @(negedge clk_4f);
        #1;
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
